// File: rtl/cmd_credit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// GLOBALS_AFU_PKG
// Shared AFU definitions used by the command credit arbiter and its credit
// counters.
//   cu_id_t             : compute-unit requester identifier
//   CREDITS_READ/WRITE  : default PSL read/write credit pool sizes
//   CREDIT_COUNTER_BITS : width of a credit pool counter (holds 0..32)
//   cmd_credit_state_t  : arbiter control states
// -----------------------------------------------------------------------------
package GLOBALS_AFU_PKG;

  localparam int CU_ID_RANGE = 8;
  typedef logic [CU_ID_RANGE-1:0] cu_id_t;

  localparam int CREDITS_READ  = 32;
  localparam int CREDITS_WRITE = 32;

  localparam int CREDIT_COUNTER_BITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cmd_credit_state_t;

endpackage

// File: rtl/cmd_credit_arbiter_credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
// One PSL credit pool. Starts full at MAX, decrements on grant, increments on
// credit_return. A simultaneous grant and return leave the count unchanged.
// A return into a full pool (without a grant) is dropped and flagged.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   grant          : one credit consumed this cycle (only issued when nonzero)
//   credit_return  : one credit returned this cycle
//   count          : registered available credits
//   nonzero        : count > 0
//   full           : count == MAX
//   overflow       : this cycle's return hit a full pool (single-cycle flag)
// -----------------------------------------------------------------------------
module credit_counter
  import GLOBALS_AFU_PKG::*;
#(
  parameter int MAX = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           grant,
  input  logic                           credit_return,
  output logic [CREDIT_COUNTER_BITS-1:0] count,
  output logic                           nonzero,
  output logic                           full,
  output logic                           overflow
);

  localparam logic [CREDIT_COUNTER_BITS-1:0] MAX_CNT = CREDIT_COUNTER_BITS'(MAX);

  assign nonzero  = (count != '0);
  assign full     = (count == MAX_CNT);
  assign overflow = credit_return && !grant && full;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= MAX_CNT;
    end else begin
      case ({grant, credit_return})
        2'b10:   if (nonzero) count <= count - 1'b1;
        2'b01:   if (!full)   count <= count + 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_credit_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_credit_arbiter
// Merges the read and write command streams into one registered command
// stream toward AFU-Control, gated by separate read/write credit pools.
// Dropping enabled_in drains the block: no new grants, and drained_out rises
// once every credit is home and the output register is empty.
//
// Optional feature: define CMD_CREDIT_STATS_EN to build the saturating stall
// counters; otherwise the stall-count outputs are tied to 0.
//
// Ports:
//   clock, reset                 : rising-edge clock, sync active-high reset
//   enabled_in                   : 1 = grants allowed, 1->0 starts drain
//   read_cmd_*  / write_cmd_*    : requester valid/ready, address, cu_id
//   cmd_valid_out / cmd_ready_in : merged output handshake
//   cmd_is_write_out, cmd_address_out, cmd_cu_id_out : granted command
//   rsp_valid_in, rsp_is_write_in: one credit returned to the selected pool
//   read_credits_out, write_credits_out : available credits (registered)
//   drained_out                  : block idle with all credits home
//   credit_error_out             : sticky, a credit was returned to a full pool
//   read/write_stall_count_out   : cycles stalled on an empty pool
// -----------------------------------------------------------------------------
module cmd_credit_arbiter
  import GLOBALS_AFU_PKG::*;
#(
  parameter int CREDITS_READ  = GLOBALS_AFU_PKG::CREDITS_READ,
  parameter int CREDITS_WRITE = GLOBALS_AFU_PKG::CREDITS_WRITE,
  parameter int CU_ID_RANGE   = GLOBALS_AFU_PKG::CU_ID_RANGE
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enabled_in,
  input  logic                           read_cmd_valid_in,
  output logic                           read_cmd_ready_out,
  input  logic [63:0]                    read_cmd_address_in,
  input  logic [CU_ID_RANGE-1:0]         read_cmd_cu_id_in,
  input  logic                           write_cmd_valid_in,
  output logic                           write_cmd_ready_out,
  input  logic [63:0]                    write_cmd_address_in,
  input  logic [CU_ID_RANGE-1:0]         write_cmd_cu_id_in,
  output logic                           cmd_valid_out,
  input  logic                           cmd_ready_in,
  output logic                           cmd_is_write_out,
  output logic [63:0]                    cmd_address_out,
  output logic [CU_ID_RANGE-1:0]         cmd_cu_id_out,
  input  logic                           rsp_valid_in,
  input  logic                           rsp_is_write_in,
  output logic [CREDIT_COUNTER_BITS-1:0] read_credits_out,
  output logic [CREDIT_COUNTER_BITS-1:0] write_credits_out,
  output logic                           drained_out,
  output logic                           credit_error_out,
  output logic [31:0]                    read_stall_count_out,
  output logic [31:0]                    write_stall_count_out
);

  cmd_credit_state_t state;
  logic last_grant_write;

  logic read_nonzero, read_full, read_overflow;
  logic write_nonzero, write_full, write_overflow;
  logic out_free, can_grant;
  logic read_elig, write_elig;
  logic grant_read, grant_write;
  logic read_ret, write_ret;

  // The output register can take a new command when empty or being consumed.
  assign out_free  = !cmd_valid_out || cmd_ready_in;
  assign can_grant = (state == RUN) && out_free && !reset;

  assign read_elig  = read_cmd_valid_in  && read_nonzero;
  assign write_elig = write_cmd_valid_in && write_nonzero;

  // Round-robin: on contention the side not granted last wins. last_grant_write
  // resets to 1 so the first contended arbitration goes to read.
  assign grant_read  = can_grant && read_elig  && (!write_elig || last_grant_write);
  assign grant_write = can_grant && write_elig && (!read_elig  || !last_grant_write);

  assign read_cmd_ready_out  = grant_read;
  assign write_cmd_ready_out = grant_write;

  assign read_ret  = rsp_valid_in && !rsp_is_write_in;
  assign write_ret = rsp_valid_in &&  rsp_is_write_in;

  credit_counter #(.MAX(CREDITS_READ)) u_read_credits (
    .clock         (clock),
    .reset         (reset),
    .grant         (grant_read),
    .credit_return (read_ret),
    .count         (read_credits_out),
    .nonzero       (read_nonzero),
    .full          (read_full),
    .overflow      (read_overflow)
  );

  credit_counter #(.MAX(CREDITS_WRITE)) u_write_credits (
    .clock         (clock),
    .reset         (reset),
    .grant         (grant_write),
    .credit_return (write_ret),
    .count         (write_credits_out),
    .nonzero       (write_nonzero),
    .full          (write_full),
    .overflow      (write_overflow)
  );

  // Control FSM, registered drained flag and output command register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      drained_out      <= 1'b1;
      credit_error_out <= 1'b0;
      last_grant_write <= 1'b1;
      cmd_valid_out    <= 1'b0;
      cmd_is_write_out <= 1'b0;
      cmd_address_out  <= '0;
      cmd_cu_id_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enabled_in) begin
            state       <= RUN;
            drained_out <= 1'b0;
          end
        end
        RUN: begin
          if (!enabled_in) state <= DRAIN;
        end
        DRAIN: begin
          if (enabled_in) begin
            state <= RUN;
          end else if (read_full && write_full && !cmd_valid_out) begin
            state       <= IDLE;
            drained_out <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          drained_out <= 1'b1;
        end
      endcase

      if (read_overflow || write_overflow) credit_error_out <= 1'b1;

      if (grant_read || grant_write) begin
        last_grant_write <= grant_write;
        cmd_valid_out    <= 1'b1;
        cmd_is_write_out <= grant_write;
        cmd_address_out  <= grant_write ? write_cmd_address_in : read_cmd_address_in;
        cmd_cu_id_out    <= grant_write ? write_cmd_cu_id_in   : read_cmd_cu_id_in;
      end else if (cmd_ready_in) begin
        cmd_valid_out <= 1'b0;
      end
    end
  end

`ifdef CMD_CREDIT_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A stall is a cycle where the requester wants to issue but its pool is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_stall_count_out  <= '0;
      write_stall_count_out <= '0;
    end else begin
      if (state == RUN && read_cmd_valid_in && !read_nonzero)
        read_stall_count_out <= sat_inc(read_stall_count_out);
      if (state == RUN && write_cmd_valid_in && !write_nonzero)
        write_stall_count_out <= sat_inc(write_stall_count_out);
    end
  end
`else
  assign read_stall_count_out  = '0;
  assign write_stall_count_out = '0;
`endif

endmodule

// File: tb/tb_cmd_credit_arbiter.sv
module tb_cmd_credit_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enabled_in;
  logic        read_cmd_valid_in;
  logic        read_cmd_ready_out;
  logic [63:0] read_cmd_address_in;
  logic [7:0]  read_cmd_cu_id_in;
  logic        write_cmd_valid_in;
  logic        write_cmd_ready_out;
  logic [63:0] write_cmd_address_in;
  logic [7:0]  write_cmd_cu_id_in;
  logic        cmd_valid_out;
  logic        cmd_ready_in;
  logic        cmd_is_write_out;
  logic [63:0] cmd_address_out;
  logic [7:0]  cmd_cu_id_out;
  logic        rsp_valid_in;
  logic        rsp_is_write_in;
  logic [5:0]  read_credits_out;
  logic [5:0]  write_credits_out;
  logic        drained_out;
  logic        credit_error_out;
  logic [31:0] read_stall_count_out;
  logic [31:0] write_stall_count_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cmd_credit_arbiter dut (
    .clock                 (clock),
    .reset                 (reset),
    .enabled_in            (enabled_in),
    .read_cmd_valid_in     (read_cmd_valid_in),
    .read_cmd_ready_out    (read_cmd_ready_out),
    .read_cmd_address_in   (read_cmd_address_in),
    .read_cmd_cu_id_in     (read_cmd_cu_id_in),
    .write_cmd_valid_in    (write_cmd_valid_in),
    .write_cmd_ready_out   (write_cmd_ready_out),
    .write_cmd_address_in  (write_cmd_address_in),
    .write_cmd_cu_id_in    (write_cmd_cu_id_in),
    .cmd_valid_out         (cmd_valid_out),
    .cmd_ready_in          (cmd_ready_in),
    .cmd_is_write_out      (cmd_is_write_out),
    .cmd_address_out       (cmd_address_out),
    .cmd_cu_id_out         (cmd_cu_id_out),
    .rsp_valid_in          (rsp_valid_in),
    .rsp_is_write_in       (rsp_is_write_in),
    .read_credits_out      (read_credits_out),
    .write_credits_out     (write_credits_out),
    .drained_out           (drained_out),
    .credit_error_out      (credit_error_out),
    .read_stall_count_out  (read_stall_count_out),
    .write_stall_count_out (write_stall_count_out)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Holds reset for two edges with all inputs idle; returns one step after an
  // edge with reset released and the DUT in IDLE.
  task automatic do_reset;
    reset                = 1'b1;
    enabled_in           = 1'b0;
    read_cmd_valid_in    = 1'b0;
    read_cmd_address_in  = '0;
    read_cmd_cu_id_in    = '0;
    write_cmd_valid_in   = 1'b0;
    write_cmd_address_in = '0;
    write_cmd_cu_id_in   = '0;
    cmd_ready_in         = 1'b0;
    rsp_valid_in         = 1'b0;
    rsp_is_write_in      = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (read_credits_out !== 6'd32) begin errors++; $display("FAIL reset_read_credits: got %0d expected 32", read_credits_out); end
    checks++; if (write_credits_out !== 6'd32) begin errors++; $display("FAIL reset_write_credits: got %0d expected 32", write_credits_out); end
    checks++; if (cmd_valid_out !== 1'b0 || cmd_is_write_out !== 1'b0) begin errors++; $display("FAIL reset_cmd_flags: got valid=%0b write=%0b expected 0 0", cmd_valid_out, cmd_is_write_out); end
    checks++; if (cmd_address_out !== 64'd0 || cmd_cu_id_out !== 8'd0) begin errors++; $display("FAIL reset_cmd_data: got addr=%0h id=%0h expected 0 0", cmd_address_out, cmd_cu_id_out); end
    checks++; if (drained_out !== 1'b1 || credit_error_out !== 1'b0) begin errors++; $display("FAIL reset_status: got drained=%0b err=%0b expected 1 0", drained_out, credit_error_out); end
    checks++; if (read_stall_count_out !== 32'd0 || write_stall_count_out !== 32'd0) begin errors++; $display("FAIL reset_stalls: got %0d %0d expected 0 0", read_stall_count_out, write_stall_count_out); end
    read_cmd_valid_in  = 1'b1;
    write_cmd_valid_in = 1'b1;
    #1;
    checks++; if (read_cmd_ready_out !== 1'b0 || write_cmd_ready_out !== 1'b0) begin errors++; $display("FAIL idle_no_ready: got r=%0b w=%0b expected 0 0", read_cmd_ready_out, write_cmd_ready_out); end
    tick;
    checks++; if (drained_out !== 1'b1 || cmd_valid_out !== 1'b0) begin errors++; $display("FAIL idle_stays_idle: got drained=%0b valid=%0b expected 1 0", drained_out, cmd_valid_out); end
  endtask

  task automatic test_read_burst;
    int          grants;
    logic        prev_grant;
    logic [63:0] prev_addr;
    logic        exp_rdy;
    grants     = 0;
    prev_grant = 1'b0;
    prev_addr  = '0;
    do_reset;
    enabled_in        = 1'b1;
    cmd_ready_in      = 1'b1;
    read_cmd_valid_in = 1'b1;
    read_cmd_cu_id_in = 8'h07;
    for (int c = 0; c <= 40; c++) begin
      if (prev_grant) begin
        checks++; if (cmd_valid_out !== 1'b1 || cmd_is_write_out !== 1'b0 || cmd_address_out !== prev_addr) begin errors++; $display("FAIL burst_out c=%0d: got v=%0b w=%0b addr=%0h expected 1 0 %0h", c, cmd_valid_out, cmd_is_write_out, cmd_address_out, prev_addr); end
      end
      read_cmd_address_in = 64'h1000 + (64'(c) << 6);
      #1;
      exp_rdy = (c >= 1 && c <= 32);
      checks++; if (read_cmd_ready_out !== exp_rdy) begin errors++; $display("FAIL burst_ready c=%0d: got %0b expected %0b", c, read_cmd_ready_out, exp_rdy); end
      prev_grant = read_cmd_ready_out;
      prev_addr  = read_cmd_address_in;
      if (read_cmd_ready_out) grants++;
      tick;
    end
    read_cmd_valid_in = 1'b0;
    checks++; if (grants !== 32) begin errors++; $display("FAIL burst_grants: got %0d expected 32", grants); end
    checks++; if (read_credits_out !== 6'd0) begin errors++; $display("FAIL burst_read_credits: got %0d expected 0", read_credits_out); end
    checks++; if (write_credits_out !== 6'd32) begin errors++; $display("FAIL burst_write_credits: got %0d expected 32", write_credits_out); end
    // Mid-operation reset restores every pool and drops the output.
    read_cmd_valid_in = 1'b1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    read_cmd_valid_in = 1'b0;
    checks++; if (read_credits_out !== 6'd32 || cmd_valid_out !== 1'b0 || drained_out !== 1'b1) begin errors++; $display("FAIL midop_reset: got credits=%0d valid=%0b drained=%0b expected 32 0 1", read_credits_out, cmd_valid_out, drained_out); end
  endtask

  task automatic test_alternate;
    int   nr, nw, prev;
    logic exp_r, exp_w;
    nr = 0; nw = 0; prev = 0;
    do_reset;
    enabled_in           = 1'b1;
    cmd_ready_in         = 1'b1;
    read_cmd_valid_in    = 1'b1;
    read_cmd_address_in  = 64'hA000;
    read_cmd_cu_id_in    = 8'h11;
    write_cmd_valid_in   = 1'b1;
    write_cmd_address_in = 64'hB000;
    write_cmd_cu_id_in   = 8'h22;
    for (int c = 0; c <= 8; c++) begin
      checks++; if (read_credits_out !== 6'(32 - nr) || write_credits_out !== 6'(32 - nw)) begin errors++; $display("FAIL alt_credits c=%0d: got %0d/%0d expected %0d/%0d", c, read_credits_out, write_credits_out, 32 - nr, 32 - nw); end
      if (prev == 1) begin
        checks++; if (cmd_valid_out !== 1'b1 || cmd_is_write_out !== 1'b0 || cmd_cu_id_out !== 8'h11 || cmd_address_out !== 64'hA000) begin errors++; $display("FAIL alt_out_read c=%0d: got v=%0b w=%0b id=%0h addr=%0h", c, cmd_valid_out, cmd_is_write_out, cmd_cu_id_out, cmd_address_out); end
      end else if (prev == 2) begin
        checks++; if (cmd_valid_out !== 1'b1 || cmd_is_write_out !== 1'b1 || cmd_cu_id_out !== 8'h22 || cmd_address_out !== 64'hB000) begin errors++; $display("FAIL alt_out_write c=%0d: got v=%0b w=%0b id=%0h addr=%0h", c, cmd_valid_out, cmd_is_write_out, cmd_cu_id_out, cmd_address_out); end
      end
      #1;
      exp_r = (c >= 1) && (c % 2 == 1);
      exp_w = (c >= 2) && (c % 2 == 0);
      checks++; if (read_cmd_ready_out !== exp_r || write_cmd_ready_out !== exp_w) begin errors++; $display("FAIL alt_ready c=%0d: got r=%0b w=%0b expected r=%0b w=%0b", c, read_cmd_ready_out, write_cmd_ready_out, exp_r, exp_w); end
      prev = read_cmd_ready_out ? 1 : (write_cmd_ready_out ? 2 : 0);
      if (read_cmd_ready_out)  nr++;
      if (write_cmd_ready_out) nw++;
      tick;
    end
    read_cmd_valid_in  = 1'b0;
    write_cmd_valid_in = 1'b0;
    checks++; if (read_credits_out !== 6'd28 || write_credits_out !== 6'd28) begin errors++; $display("FAIL alt_final_credits: got %0d/%0d expected 28/28", read_credits_out, write_credits_out); end
  endtask

  task automatic test_backpressure;
    do_reset;
    enabled_in          = 1'b1;
    cmd_ready_in        = 1'b0;
    read_cmd_valid_in   = 1'b1;
    read_cmd_address_in = 64'h00C0;
    read_cmd_cu_id_in   = 8'h03;
    tick;
    #1;
    checks++; if (read_cmd_ready_out !== 1'b1) begin errors++; $display("FAIL bp_first_grant: got %0b expected 1", read_cmd_ready_out); end
    tick;
    read_cmd_address_in = 64'h00D0;
    #1;
    checks++; if (read_cmd_ready_out !== 1'b0) begin errors++; $display("FAIL bp_blocked: got %0b expected 0", read_cmd_ready_out); end
    tick;
    checks++; if (cmd_valid_out !== 1'b1 || cmd_address_out !== 64'h00C0 || read_credits_out !== 6'd31) begin errors++; $display("FAIL bp_hold: got v=%0b addr=%0h credits=%0d expected 1 c0 31", cmd_valid_out, cmd_address_out, read_credits_out); end
    cmd_ready_in = 1'b1;
    #1;
    checks++; if (read_cmd_ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_grant: got %0b expected 1", read_cmd_ready_out); end
    tick;
    read_cmd_valid_in = 1'b0;
    checks++; if (cmd_valid_out !== 1'b1 || cmd_address_out !== 64'h00D0 || read_credits_out !== 6'd30) begin errors++; $display("FAIL bp_second: got v=%0b addr=%0h credits=%0d expected 1 d0 30", cmd_valid_out, cmd_address_out, read_credits_out); end
    tick;
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b expected 0", cmd_valid_out); end
  endtask

  task automatic test_same_cycle;
    int grants;
    grants = 0;
    do_reset;
    enabled_in        = 1'b1;
    cmd_ready_in      = 1'b1;
    read_cmd_valid_in = 1'b1;
    tick;
    for (int c = 0; c < 100 && grants < 27; c++) begin
      #1;
      if (read_cmd_ready_out) grants++;
      tick;
    end
    read_cmd_valid_in = 1'b0;
    tick;
    checks++; if (read_credits_out !== 6'd5) begin errors++; $display("FAIL same_setup: got %0d expected 5", read_credits_out); end
    read_cmd_valid_in = 1'b1;
    rsp_valid_in      = 1'b1;
    rsp_is_write_in   = 1'b0;
    #1;
    checks++; if (read_cmd_ready_out !== 1'b1) begin errors++; $display("FAIL same_grant: got %0b expected 1", read_cmd_ready_out); end
    tick;
    read_cmd_valid_in = 1'b0;
    rsp_valid_in      = 1'b0;
    checks++; if (read_credits_out !== 6'd5 || credit_error_out !== 1'b0) begin errors++; $display("FAIL same_net_zero: got credits=%0d err=%0b expected 5 0", read_credits_out, credit_error_out); end
  endtask

  task automatic test_overflow;
    do_reset;
    rsp_valid_in    = 1'b1;
    rsp_is_write_in = 1'b0;
    tick;
    rsp_valid_in = 1'b0;
    checks++; if (read_credits_out !== 6'd32 || write_credits_out !== 6'd32) begin errors++; $display("FAIL ovf_hold: got %0d/%0d expected 32/32", read_credits_out, write_credits_out); end
    checks++; if (credit_error_out !== 1'b1) begin errors++; $display("FAIL ovf_error_set: got %0b expected 1", credit_error_out); end
    tick;
    tick;
    checks++; if (credit_error_out !== 1'b1) begin errors++; $display("FAIL ovf_error_sticky: got %0b expected 1", credit_error_out); end
  endtask

  task automatic test_drain;
    int grants;
    grants = 0;
    do_reset;
    enabled_in           = 1'b1;
    cmd_ready_in         = 1'b1;
    write_cmd_valid_in   = 1'b1;
    write_cmd_address_in = 64'h00E0;
    write_cmd_cu_id_in   = 8'h05;
    tick;
    for (int c = 0; c < 20 && grants < 3; c++) begin
      #1;
      if (write_cmd_ready_out) grants++;
      tick;
    end
    write_cmd_valid_in = 1'b0;
    enabled_in         = 1'b0;
    tick;
    write_cmd_valid_in = 1'b1;
    #1;
    checks++; if (write_cmd_ready_out !== 1'b0) begin errors++; $display("FAIL drain_no_grant: got %0b expected 0", write_cmd_ready_out); end
    checks++; if (write_credits_out !== 6'd29 || drained_out !== 1'b0) begin errors++; $display("FAIL drain_start: got credits=%0d drained=%0b expected 29 0", write_credits_out, drained_out); end
    tick;
    for (int r = 1; r <= 3; r++) begin
      rsp_valid_in    = 1'b1;
      rsp_is_write_in = 1'b1;
      #1;
      checks++; if (write_cmd_ready_out !== 1'b0) begin errors++; $display("FAIL drain_rsp_no_grant r=%0d: got %0b expected 0", r, write_cmd_ready_out); end
      tick;
      checks++; if (write_credits_out !== 6'(29 + r) || drained_out !== 1'b0) begin errors++; $display("FAIL drain_rsp r=%0d: got credits=%0d drained=%0b expected %0d 0", r, write_credits_out, drained_out, 29 + r); end
    end
    rsp_valid_in = 1'b0;
    tick;
    checks++; if (drained_out !== 1'b1 || cmd_valid_out !== 1'b0) begin errors++; $display("FAIL drain_done: got drained=%0b valid=%0b expected 1 0", drained_out, cmd_valid_out); end
    #1;
    checks++; if (write_cmd_ready_out !== 1'b0) begin errors++; $display("FAIL drain_idle_no_grant: got %0b expected 0", write_cmd_ready_out); end
    write_cmd_valid_in = 1'b0;
  endtask

  task automatic test_stats;
    int          grants;
    logic [31:0] exp_stall;
`ifdef CMD_CREDIT_STATS_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    grants = 0;
    do_reset;
    enabled_in         = 1'b1;
    cmd_ready_in       = 1'b1;
    write_cmd_valid_in = 1'b1;
    tick;
    for (int c = 0; c < 100 && grants < 32; c++) begin
      #1;
      if (write_cmd_ready_out) grants++;
      tick;
    end
    checks++; if (write_credits_out !== 6'd0 || write_stall_count_out !== 32'd0) begin errors++; $display("FAIL stats_setup: got credits=%0d stall=%0d expected 0 0", write_credits_out, write_stall_count_out); end
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (write_cmd_ready_out !== 1'b0) begin errors++; $display("FAIL stats_no_grant c=%0d: got %0b expected 0", c, write_cmd_ready_out); end
      tick;
    end
    write_cmd_valid_in = 1'b0;
    checks++; if (write_stall_count_out !== exp_stall) begin errors++; $display("FAIL stats_write_stall: got %0d expected %0d", write_stall_count_out, exp_stall); end
    tick;
    checks++; if (write_stall_count_out !== exp_stall || read_stall_count_out !== 32'd0) begin errors++; $display("FAIL stats_hold: got w=%0d r=%0d expected %0d 0", write_stall_count_out, read_stall_count_out, exp_stall); end
  endtask

  initial begin
    test_reset;
    test_read_burst;
    test_alternate;
    test_backpressure;
    test_same_cycle;
    test_overflow;
    test_drain;
    test_stats;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
